matmul_load_seq: RTL and testbench
==================================

// Module: matmul_load_seq
// PURPOSE
//  Upstream feeder/sequencer for the matrix-multiply top.
//  - Accepts a 32-bit word stream and packs it into 128-bit SRAM rows.
//  - Writes all rows of matrix A, then all rows of B, through SRAM port B (MA_*/MB_* b-side).
//  - Pulses the core Go, waits for Done, then captures the 512-bit product and offers it downstream.
// PARAMETERS
//  ADDR_W      1       SRAM row address width; rows per matrix NROWS = 2**ADDR_W
//  WORD_W      32      input stream word width; WPR = 128/WORD_W words per row (must divide 128)
//  TIMEOUT     1024    max cycles in WAIT_DONE before Err is raised
// PORTS
//  Clk         in   1        system clock, all logic on rising edge
//  Rst_n       in   1        asynchronous active-low reset
//  In_data     in   WORD_W   input word
//  In_valid    in   1        In_data valid
//  In_ready    out  1        block accepts In_data this cycle
//  MA_dib      out  128      row data to SRAM A port B
//  MA_Addrb    out  ADDR_W   row address, SRAM A port B
//  MA_enb      out  1        enable, SRAM A port B
//  MA_web      out  1        write enable, SRAM A port B
//  MB_dib      out  128      row data to SRAM B port B
//  MB_Addrb    out  ADDR_W   row address, SRAM B port B
//  MB_enb      out  1        enable, SRAM B port B
//  MB_web      out  1        write enable, SRAM B port B
//  Go_t        out  1        start request to multiply core
//  Done_t      in   1        core completion
//  MULT_OUT_t  in   512      core result, sampled when Done_t=1
//  Res_data    out  512      captured result
//  Res_valid   out  1        Res_data valid
//  Res_ready   in   1        downstream accepts result
//  Err         out  1        sticky timeout flag; cleared only by reset
// BEHAVIOUR
//  Reset (Rst_n=0, async): state IDLE; all outputs 0; word/row counters and pack register 0.
//  FSM states: LOAD_A, WR_A, LOAD_B, WR_B, GO, WAIT_DONE, RESULT. IDLE leaves to LOAD_A on the next cycle.
//  LOAD_x
//   - In_ready=1.
//   - Word accepted when In_valid&In_ready.
//   - k-th word of a row (k=0..WPR-1) goes to row bits [k*WORD_W +: WORD_W] (first word = LSBs).
//   - On acceptance of word WPR-1, go to WR_x.
//  WR_x (exactly 1 cycle)
//   - In_ready=0.
//   - Mx_enb=Mx_web=1, Mx_Addrb=row counter, Mx_dib=packed row.
//   - The other SRAM's en/we are 0.
//   - Row counter increments (wraps to 0 after NROWS-1).
//   - Next state: if row was NROWS-1, WR_A->LOAD_B and WR_B->GO; else back to LOAD_x.
//  Outside WR_x: en/we=0; dib/Addrb hold their last value.
//  GO (1 cycle)
//   - Go_t=1.
//   - Go to WAIT_DONE, timeout counter cleared.
//  WAIT_DONE
//   - Go_t=0; timeout counter increments each cycle.
//   - Done_t=1: Res_data<=MULT_OUT_t, Res_valid=1 next cycle, go to RESULT.
//   - If the counter reaches TIMEOUT-1 without Done_t: Err=1, go to LOAD_A (result discarded).
//   - Done_t in the same cycle as the timeout: Done wins, no Err.
//  RESULT
//   - Res_valid=1, Res_data stable until Res_valid&Res_ready.
//   - On handshake: Res_valid=0 next cycle, go to LOAD_A.
//  Handshake timing
//   - In_ready is a registered function of state (no comb path from In_valid).
//   - In_ready=0 in WR_x/GO/WAIT_DONE/RESULT; words offered then are held by the sender.
//  Done_t seen outside WAIT_DONE: ignored.
//  Throughput: NROWS*(WPR+1)*2 + 1 + core latency + 1 cycles per matrix pair with In_valid stuck high.
//  Mid-operation reset: immediate return to reset values; partially loaded rows are lost; SRAM content untouched.
// STRUCTURE
//  Shared package/include (matmul_defs): ROW_W=128, RES_W=512, FSM state encodings.
//  One sub-module: matmul_row_packer (word counter + pack register, emits row_full pulse and 128-bit row).
//  FSM, row/timeout counters and result register stay in the top of this block.
// TESTING
//  1 Reset: Rst_n low mid-LOAD_B with In_valid=1 -> all outputs 0 immediately; after release In_ready=1, state LOAD_A.
//  2 Packing (ADDR_W=1, WORD_W=32): words 0x00000001..0x00000004 ->
//    MA_web=1 for one cycle, MA_Addrb=0, MA_dib=0x00000004_00000003_00000002_00000001.
//  3 Full load: 16 words, In_valid stuck high ->
//    - A rows 0,1 then B rows 0,1 written;
//    - In_ready low exactly in the 4 write cycles;
//    - Go_t single pulse one cycle after the B row-1 write.
//  4 Result: core model asserts Done_t 10 cycles after Go with MULT_OUT_t=512'hA5..A5, Res_ready=0 for 5 cycles ->
//    Res_valid held, Res_data stable; cleared the cycle after Res_ready=1.
//  5 Timeout (TIMEOUT=16): Done_t never asserted ->
//    Err=1 at cycle 16 after Go, back in LOAD_A, Err stays 1 through the next load.
//  6 Backpressure: random In_valid gaps and a Done_t pulse during LOAD_A ->
//    packed rows match the reference model; spurious Done_t ignored.

Source files
------------

// File: rtl/matmul_defs.sv
// Shared widths and FSM state encoding for the matrix-multiply load sequencer.
package matmul_defs;

  localparam int ROW_W = 128;
  localparam int RES_W = 512;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD_A    = 3'd1,
    ST_WR_A      = 3'd2,
    ST_LOAD_B    = 3'd3,
    ST_WR_B      = 3'd4,
    ST_GO        = 3'd5,
    ST_WAIT_DONE = 3'd6,
    ST_RESULT    = 3'd7
  } state_e;

endpackage

// File: rtl/matmul_row_packer.sv
// Packs accepted stream words into a 128-bit row, first word in the LSBs.
// row_full_o pulses on the last word; row_o already includes that word.
module matmul_row_packer
  import matmul_defs::*;
#(
  parameter int WORD_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              accept_i,
  input  logic [WORD_W-1:0] word_i,
  output logic              row_full_o,
  output logic [ROW_W-1:0]  row_o
);

  localparam int WPR   = ROW_W / WORD_W;
  localparam int CNT_W = (WPR > 1) ? $clog2(WPR) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ROW_W-1:0] pack_q, pack_d;
  logic             last_word;

  assign last_word = (cnt_q == CNT_W'(WPR - 1));

  always_comb begin
    pack_d = pack_q;
    cnt_d  = cnt_q;
    if (accept_i) begin
      pack_d[int'(cnt_q) * WORD_W +: WORD_W] = word_i;
      cnt_d = last_word ? '0 : cnt_q + CNT_W'(1);
    end
  end

  assign row_full_o = accept_i && last_word;
  assign row_o      = pack_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      pack_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      pack_q <= pack_d;
    end
  end

endmodule

// File: rtl/matmul_load_seq.sv
// Feeds matrix A then B rows into the SRAM b-ports, starts the multiply core,
// waits (bounded) for Done and hands the 512-bit product downstream.
module matmul_load_seq
  import matmul_defs::*;
#(
  parameter int ADDR_W  = 1,
  parameter int WORD_W  = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic [WORD_W-1:0] In_data,
  input  logic              In_valid,
  output logic              In_ready,
  output logic [ROW_W-1:0]  MA_dib,
  output logic [ADDR_W-1:0] MA_Addrb,
  output logic              MA_enb,
  output logic              MA_web,
  output logic [ROW_W-1:0]  MB_dib,
  output logic [ADDR_W-1:0] MB_Addrb,
  output logic              MB_enb,
  output logic              MB_web,
  output logic              Go_t,
  input  logic              Done_t,
  input  logic [RES_W-1:0]  MULT_OUT_t,
  output logic [RES_W-1:0]  Res_data,
  output logic              Res_valid,
  input  logic              Res_ready,
  output logic              Err
);

  localparam int NROWS = 2 ** ADDR_W;
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  state_e            state_q;
  logic              in_ready_q;
  logic [ROW_W-1:0]  ma_dib_q, mb_dib_q;
  logic [ADDR_W-1:0] ma_addr_q, mb_addr_q;
  logic              ma_wr_q, mb_wr_q;
  logic [ADDR_W-1:0] row_q;
  logic [TMO_W-1:0]  tmo_q;
  logic              go_q;
  logic [RES_W-1:0]  res_data_q;
  logic              res_valid_q;
  logic              err_q;

  logic              accept;
  logic              row_full;
  logic [ROW_W-1:0]  packed_row;
  logic              last_row;
  logic [TMO_W-1:0]  tmo_d;

  // in_ready_q is only ever high in LOAD_x, so no state qualifier is needed here.
  assign accept   = In_valid && in_ready_q;
  assign last_row = (row_q == ADDR_W'(NROWS - 1));
  assign tmo_d    = tmo_q + TMO_W'(1);

  matmul_row_packer #(
    .WORD_W(WORD_W)
  ) u_packer (
    .clk_i     (Clk),
    .rst_ni    (Rst_n),
    .accept_i  (accept),
    .word_i    (In_data),
    .row_full_o(row_full),
    .row_o     (packed_row)
  );

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q     <= ST_IDLE;
      in_ready_q  <= 1'b0;
      ma_dib_q    <= '0;
      mb_dib_q    <= '0;
      ma_addr_q   <= '0;
      mb_addr_q   <= '0;
      ma_wr_q     <= 1'b0;
      mb_wr_q     <= 1'b0;
      row_q       <= '0;
      tmo_q       <= '0;
      go_q        <= 1'b0;
      res_data_q  <= '0;
      res_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      ma_wr_q <= 1'b0;
      mb_wr_q <= 1'b0;
      go_q    <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          state_q    <= ST_LOAD_A;
          in_ready_q <= 1'b1;
        end
        ST_LOAD_A: begin
          if (row_full) begin
            in_ready_q <= 1'b0;
            ma_wr_q    <= 1'b1;
            ma_dib_q   <= packed_row;
            ma_addr_q  <= row_q;
            state_q    <= ST_WR_A;
          end
        end
        ST_LOAD_B: begin
          if (row_full) begin
            in_ready_q <= 1'b0;
            mb_wr_q    <= 1'b1;
            mb_dib_q   <= packed_row;
            mb_addr_q  <= row_q;
            state_q    <= ST_WR_B;
          end
        end
        ST_WR_A: begin
          row_q      <= row_q + ADDR_W'(1);
          in_ready_q <= 1'b1;
          state_q    <= last_row ? ST_LOAD_B : ST_LOAD_A;
        end
        ST_WR_B: begin
          row_q <= row_q + ADDR_W'(1);
          if (last_row) begin
            go_q    <= 1'b1;
            state_q <= ST_GO;
          end else begin
            in_ready_q <= 1'b1;
            state_q    <= ST_LOAD_B;
          end
        end
        ST_GO: begin
          tmo_q   <= '0;
          state_q <= ST_WAIT_DONE;
        end
        ST_WAIT_DONE: begin
          // Done has priority over a timeout landing in the same cycle.
          if (Done_t) begin
            res_data_q  <= MULT_OUT_t;
            res_valid_q <= 1'b1;
            state_q     <= ST_RESULT;
          end else if (tmo_d == TMO_W'(TIMEOUT - 1)) begin
            err_q      <= 1'b1;
            in_ready_q <= 1'b1;
            state_q    <= ST_LOAD_A;
          end else begin
            tmo_q <= tmo_d;
          end
        end
        ST_RESULT: begin
          if (Res_ready) begin
            res_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= ST_LOAD_A;
          end
        end
        default: begin
          in_ready_q <= 1'b0;
          state_q    <= ST_IDLE;
        end
      endcase
    end
  end

  assign In_ready  = in_ready_q;
  assign MA_dib    = ma_dib_q;
  assign MA_Addrb  = ma_addr_q;
  assign MA_enb    = ma_wr_q;
  assign MA_web    = ma_wr_q;
  assign MB_dib    = mb_dib_q;
  assign MB_Addrb  = mb_addr_q;
  assign MB_enb    = mb_wr_q;
  assign MB_web    = mb_wr_q;
  assign Go_t      = go_q;
  assign Res_data  = res_data_q;
  assign Res_valid = res_valid_q;
  assign Err       = err_q;

endmodule

// File: tb/tb_matmul_load_seq.sv
// Randomised bench for matmul_load_seq: a queue of accepted words predicts every
// SRAM row write; result handshake, timeout and reset are checked in-line.
module tb_matmul_load_seq;

  localparam int ADDR_W  = 1;
  localparam int WORD_W  = 32;
  localparam int TIMEOUT = 16;
  localparam int NROWS   = 2 ** ADDR_W;
  localparam int WPR     = 128 / WORD_W;

  logic              Clk = 1'b0;
  logic              Rst_n;
  logic [WORD_W-1:0] In_data;
  logic              In_valid;
  logic              In_ready;
  logic [127:0]      MA_dib, MB_dib;
  logic [ADDR_W-1:0] MA_Addrb, MB_Addrb;
  logic              MA_enb, MA_web, MB_enb, MB_web;
  logic              Go_t;
  logic              Done_t;
  logic [511:0]      MULT_OUT_t;
  logic [511:0]      Res_data;
  logic              Res_valid;
  logic              Res_ready;
  logic              Err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [WORD_W-1:0] words_q[$];
  bit                exp_mat;
  int                exp_row;
  bit                go_exp;

  matmul_load_seq #(
    .ADDR_W (ADDR_W),
    .WORD_W (WORD_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .In_data   (In_data),
    .In_valid  (In_valid),
    .In_ready  (In_ready),
    .MA_dib    (MA_dib),
    .MA_Addrb  (MA_Addrb),
    .MA_enb    (MA_enb),
    .MA_web    (MA_web),
    .MB_dib    (MB_dib),
    .MB_Addrb  (MB_Addrb),
    .MB_enb    (MB_enb),
    .MB_web    (MB_web),
    .Go_t      (Go_t),
    .Done_t    (Done_t),
    .MULT_OUT_t(MULT_OUT_t),
    .Res_data  (Res_data),
    .Res_valid (Res_valid),
    .Res_ready (Res_ready),
    .Err       (Err)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [511:0] rand512();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Row model: every write consumes the next WPR accepted words, A rows then B rows.
  always @(negedge Clk) begin
    logic [127:0] exp_data;
    if (!Rst_n) begin
      words_q.delete();
      exp_mat = 1'b0;
      exp_row = 0;
      go_exp  = 1'b0;
    end else begin
      if (Go_t || go_exp) check("go_pulse", Go_t, go_exp);
      go_exp = 1'b0;
      if (MA_web || MB_web) begin
        exp_data = '0;
        if (words_q.size() < WPR) check("wr_words_avail", words_q.size(), WPR);
        else for (int k = 0; k < WPR; k++) exp_data[k*WORD_W +: WORD_W] = words_q.pop_front();
        check("wr_sel", {MA_enb, MA_web, MB_enb, MB_web}, exp_mat ? 4'b0011 : 4'b1100);
        check("wr_addr", exp_mat ? MB_Addrb : MA_Addrb, exp_row);
        check("wr_data", exp_mat ? MB_dib : MA_dib, exp_data);
        $display("row write mat=%s row=%0d data=%h", exp_mat ? "B" : "A", exp_row, exp_data);
        if (exp_mat && exp_row == NROWS - 1) go_exp = 1'b1;
        exp_row++;
        if (exp_row == NROWS) begin
          exp_row = 0;
          exp_mat = !exp_mat;
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctrl"}, {In_ready, MA_enb, MA_web, MB_enb, MB_web, Go_t, Res_valid, Err,
                           MA_Addrb, MB_Addrb}, '0);
    check({tag, "_ma_dib"}, MA_dib, '0);
    check({tag, "_mb_dib"}, MB_dib, '0);
    check({tag, "_res_data"}, Res_data, '0);
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 6 && !In_ready; i++) @(negedge Clk);
    check("ready_after_reset", In_ready, 1'b1);
  endtask

  task automatic wait_go();
    for (int i = 0; i < 20 && !Go_t; i++) @(negedge Clk);
    check("go_seen", Go_t, 1'b1);
  endtask

  // Offers n words, holding each until accepted; seq gives 1,2,3,... words.
  task automatic send_words(input int n, input int gap_pct, input bit seq, input bit spur,
                            output int lows);
    int sent = 0;
    int guard = 0;
    logic [WORD_W-1:0] w;
    lows = 0;
    w = seq ? WORD_W'(1) : WORD_W'($urandom);
    while (sent < n && guard < 2000) begin
      In_valid = ($urandom_range(99) >= gap_pct);
      In_data  = w;
      Done_t   = spur && (guard == 6);
      if (Done_t) MULT_OUT_t = rand512();
      if (In_valid && In_ready) begin
        words_q.push_back(w);
        sent++;
        w = seq ? WORD_W'(sent + 1) : WORD_W'($urandom);
      end else if (In_valid) begin
        lows++;
      end
      @(negedge Clk);
      guard++;
    end
    In_valid = 1'b0;
    Done_t   = 1'b0;
    if (guard >= 2000) check("send_bound", sent, n);
  endtask

  // Called at the negedge where Go_t is seen; Done_t is sampled lat cycles later.
  task automatic core_done(input int lat, input logic [511:0] data);
    repeat (lat - 1) @(negedge Clk);
    check("pre_done_valid", Res_valid, 1'b0);
    @(negedge Clk);
    Done_t     = 1'b1;
    MULT_OUT_t = data;
    @(negedge Clk);
    Done_t     = 1'b0;
    MULT_OUT_t = rand512();
    check("res_valid_set", Res_valid, 1'b1);
    check("res_data", Res_data, data);
    check("no_err", Err, 1'b0);
    $display("result captured lat=%0d data=%h", lat, Res_data);
  endtask

  initial begin
    int lows;
    logic [511:0] res;
    bit rdy;

    Rst_n = 1'b0; In_valid = 1'b0; In_data = '0;
    Done_t = 1'b0; MULT_OUT_t = '0; Res_ready = 1'b0;
    repeat (3) @(negedge Clk);
    check_reset_outputs("rst0");
    Rst_n = 1'b1;
    wait_ready();

    // Words 1..16 with In_valid stuck high; the B row-1 write follows the last word.
    send_words(16, 0, 1'b1, 1'b0, lows);
    check("load_ready_lows", lows, 3);
    check("wr_b1_cycle", {In_ready, MB_web}, 2'b01);
    @(negedge Clk);
    check("go_after_wrb1", Go_t, 1'b1);
    core_done(10, {16{32'hA5A5A5A5}});
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      check("res_hold_valid", Res_valid, 1'b1);
      check("res_hold_data", Res_data, {16{32'hA5A5A5A5}});
    end
    Res_ready = 1'b1;
    @(negedge Clk);
    Res_ready = 1'b0;
    check("res_cleared", Res_valid, 1'b0);
    check("back_to_load", In_ready, 1'b1);

    // Gappy input with a stray Done_t; Done_t lands on the timeout boundary cycle.
    send_words(16, 40, 1'b0, 1'b1, lows);
    check("spur_done_ignored", Res_valid, 1'b0);
    wait_go();
    res = rand512();
    core_done(TIMEOUT - 1, res);
    for (int i = 0; i < 60; i++) begin
      rdy = 1'($urandom_range(1));
      Res_ready = rdy;
      @(negedge Clk);
      if (rdy) break;
      check("res_bp_data", Res_data, res);
      check("res_bp_valid", Res_valid, 1'b1);
    end
    Res_ready = 1'b0;
    check("res_bp_done", Res_valid, 1'b0);

    // Core never answers: Err at cycle TIMEOUT after Go, then reloading restarts.
    send_words(16, 20, 1'b0, 1'b0, lows);
    wait_go();
    repeat (TIMEOUT - 1) @(negedge Clk);
    check("err_before_tmo", Err, 1'b0);
    @(negedge Clk);
    check("err_at_tmo", Err, 1'b1);
    check("tmo_ready", In_ready, 1'b1);
    check("tmo_no_result", Res_valid, 1'b0);
    $display("timeout flagged");

    // Reset in the middle of LOAD_B with a word on offer.
    send_words(2 * WPR + 2, 30, 1'b0, 1'b0, lows);
    check("err_sticky", Err, 1'b1);
    In_valid = 1'b1;
    In_data  = $urandom;
    #2 Rst_n = 1'b0;
    #1 check_reset_outputs("rst_mid");
    @(negedge Clk);
    @(negedge Clk);
    In_valid = 1'b0;
    Rst_n    = 1'b1;
    wait_ready();
    send_words(WPR, 0, 1'b0, 1'b0, lows);
    repeat (3) @(negedge Clk);
    check("post_reset_err", Err, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

endmodule
